// File: rtl/port_arbiter_if.sv
// Requester/link bundle for one router output port: packet requests in, serialized bytes out.
// The arbiter connects through `master`; the requester/downstream side uses `slave`.
interface port_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0][31:0] pkt_in;
  logic [NUM_REQ-1:0]       ack;
  logic                     free_out;
  logic                     put_out;
  logic [7:0]               payload_out;
  logic                     busy;
  logic [2:0]               grant_id;

  modport master (
    input  req, pkt_in, free_out,
    output ack, put_out, payload_out, busy, grant_id
  );

  modport slave (
    output req, pkt_in, free_out,
    input  ack, put_out, payload_out, busy, grant_id
  );
endinterface

// File: rtl/port_arbiter.sv
// Round-robin arbiter and 4-byte serializer sharing one 8-bit put/free link
// among NUM_REQ packet requesters.
module port_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic           clock,
  input  logic           reset,
  port_arbiter_if.master bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [31:0]          sreg_q, sreg_d;
  logic [2:0]           grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;

  logic [NUM_REQ-1:0]   hi_oh, lo_oh, win_oh;
  logic [2:0]           win_id;
  logic [31:0]          win_pkt;

  // Requesters above the last grant outrank those at or below it; the
  // descending scan leaves the lowest-numbered candidate of each group.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hi_oh = '0;
    lo_oh = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        if (i > int'(grant_id_q)) hi_oh = NUM_REQ'(1) << i;
        else                      lo_oh = NUM_REQ'(1) << i;
      end
    end
    win_oh = (|hi_oh) ? hi_oh : lo_oh;
  end

  always_comb begin
    win_id  = '0;
    win_pkt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_id  = 3'(i);
        win_pkt = bus.pkt_in[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    grant_id_d = grant_id_q;
    ack_d      = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.free_out && (|bus.req)) begin
          sreg_d     = win_pkt;
          cnt_d      = 2'd0;
          grant_id_d = win_id;
          ack_d      = win_oh;
          state_d    = SEND;
        end
      end
      SEND: begin
        // Zero fill leaves the link byte at 0 once the packet has drained.
        sreg_d = {sreg_q[23:0], 8'h00};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is asynchronous so an in-flight packet is cut off in the same cycle.
  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      sreg_q     <= 32'h0;
      grant_id_q <= 3'(NUM_REQ - 1);
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      grant_id_q <= grant_id_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.put_out     = (state_q == SEND);
  assign bus.busy        = (state_q == SEND);
  assign bus.payload_out = sreg_q[31:24];
  assign bus.ack         = ack_q;
  assign bus.grant_id    = grant_id_q;

endmodule

// File: doc/port_arbiter.md
# port_arbiter

Round-robin arbiter and serializer for one NoC router output port. It shares a single 8-bit put/free link among `NUM_REQ` input-side requesters, each presenting a complete 32-bit packet. It sends the granted packet as four consecutive bytes to the downstream node or router, then re-arbitrates. It sits between the router's per-input packet buffers and each outbound link.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  `NUM_REQ`  bit i high means requester i holds a valid packet on `pkt_in[i]`.
- `pkt_in`  in  `NUM_REQ`x32  per-requester packet: [31:28] src, [27:24] dest, [23:0] data.
- `ack`  out  `NUM_REQ`  one-hot, one-cycle pulse: packet i was captured; requester pops it.
- `free_out`  in  1  downstream link can accept a new packet.
- `put_out`  out  1  byte on `payload_out` is valid this cycle.
- `payload_out`  out  8  serialized packet byte.
- `busy`  out  1  a transfer is in progress (state SEND).
- `grant_id`  out  3  index of the last granted requester.

## Operation
- Two states plus a 2-bit byte counter `cnt` and a 32-bit shift register `sreg`.
- **IDLE**
  - `put_out`=0, `busy`=0.
  - If `free_out`=1 and `|req`=1 on a rising edge, choose winner w by round-robin.
  - Scan starts at `grant_id`+1 (mod `NUM_REQ`) and wraps upward; the first set `req` bit wins.
  - On that edge: `sreg`<=`pkt_in[w]`, `cnt`<=0, `grant_id`<=w, `ack`<=onehot(w), state<=SEND.
  - Otherwise stay in IDLE; `ack`=0.
- **SEND**
  - `put_out`=1, `busy`=1, `payload_out`=`sreg[31:24]`.
  - Each edge: `sreg`<=`sreg`<<8 and `cnt`<=`cnt`+1.
  - When `cnt`=3, state<=IDLE.
  - Byte order on the link: {src,dest}, data[23:16], data[15:8], data[7:0].
- Once started, a transfer always completes four bytes. `free_out` is ignored in SEND; downstream deasserting free during receipt is expected.
- `req` is ignored in SEND. No new grant can occur until at least one IDLE cycle has elapsed.
- `pkt_in[i]` is sampled only on the grant edge. The requester must hold it stable while `req[i]`=1.
- If `req[i]` drops before being granted, no grant or ack is issued for it.
- `ack` is registered and high for exactly the first SEND cycle. During that same cycle the requester may present its next packet on `req[i]`/`pkt_in[i]`.
- A requester granted last has lowest priority at the next arbitration. With all requesters continuously requesting, service order is strictly cyclic.

## Timing
- Reset values, applied immediately on `reset` assertion: state IDLE, `put_out`=0, `payload_out`=0, `ack`=0, `busy`=0, `cnt`=0, `sreg`=0, `grant_id`=`NUM_REQ`-1 (requester 0 has top priority first).
- Reset mid-SEND aborts the packet at once. `put_out` falls in the same cycle; no further bytes are sent.
- Grant latency:
  - Edge E with `free_out`&`|req` produces `put_out`=1 and `ack` from E through E+1.
  - Bytes 0..3 appear in cycles E..E+3 after the edge.
  - State returns to IDLE after edge E+4.
- Minimum packet spacing is 5 cycles: 4 SEND plus 1 IDLE. Peak link utilisation is 80%.
- `free_out`=0 in IDLE holds the arbiter indefinitely; `grant_id` and priority are unchanged.
- Single requester continuously requesting with `free_out`=1 is served every 5 cycles.

## Test plan
- **Reset values:** assert `reset` and check all outputs; `grant_id`=3 for `NUM_REQ`=4.
- **Single packet:** `req`=0001, `pkt_in[0]`=0x12ABCDEF, `free_out`=1.
  - `ack`=0001 for exactly one cycle.
  - `put_out` high 4 cycles with bytes 0x12, 0xAB, 0xCD, 0xEF.
  - `busy` falls afterwards and `grant_id`=0.
- **Fairness:** `req`=1111 held with distinct packets and `free_out`=1.
  - Grants go 0,1,2,3,0; each start is 5 cycles apart.
  - `ack` pulses follow the same order.
- **Priority rotation and wrap:** with `grant_id`=2, set `req`=1001. Requester 3 wins; the next grant with `req`=1001 goes to 0.
- **Backpressure:** `req`=0100 with `free_out`=0 for 10 cycles gives no `put_out` and no `ack`.
  - When `free_out` rises, the transfer starts next edge.
  - Dropping `free_out` after byte 1 still yields all 4 bytes.
- **Abort:** assert `reset` during byte 2 of packet 0x5A000001. `put_out` falls immediately and no byte 0x01 ever appears. After release, with `req` still high, the same packet is resent from byte 0x5A.
